adld_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs wide (4·NIBBLES-bit) additions by time-multiplexing a single 4-bit ripple-carry adder slice. One nibble is processed per clock, and the carry is held in a register between nibbles. Operands enter and results leave over valid/ready handshakes. The block sits between a requester (CPU-side register file or test driver) and the shared 4-bit adder datapath, trading latency for area.

---
 rtl/adld_pkg.sv | 18 +
 rtl/adld_nibble_add.sv | 25 ++
 rtl/adld_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_adld_seq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/adld_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// The optional signed-overflow output of adld_seq_ctrl is enabled by ADLD_OVF_EN.
package adld_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Width of the nibble index; kept at least one bit so the counter always exists.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/adld_nibble_add.sv
// Combinational 4-bit ripple-carry adder slice built from full-adder cells.
module adld_nibble_add
    import adld_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/adld_seq_ctrl.sv
// Wide adder that reuses one 4-bit slice, one nibble per clock, with valid/ready handshakes.
// Define ADLD_OVF_EN to add the registered two's-complement overflow output ovf.
module adld_seq_ctrl
    import adld_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLES*NIBBLE_W-1:0]  a,
    input  logic [NIBBLES*NIBBLE_W-1:0]  b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]  sum,
    output logic                         cout,
`ifdef ADLD_OVF_EN
    output logic                         ovf,
`endif
    output logic                         busy
);

    localparam int W  = NIBBLES * NIBBLE_W;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t state_reg;
    state_t state_next;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic [IW-1:0] idx_reg;

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                last_nib;

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    adld_nibble_add u_slice (
        .a    (a_nib[idx_reg]),
        .b    (b_nib[idx_reg]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last_nib = (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only at acceptance, so later input changes are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (last_nib) begin
                        cout_reg <= slice_cout;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADLD_OVF_EN
    logic ovf_reg;

    // The slice MSB on the final nibble is the result sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_nib) begin
            ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[NIBBLE_W-1] != a_reg[W-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_adld_seq_ctrl.sv
// Directed test of adld_seq_ctrl (NIBBLES=4): arithmetic, latency, backpressure, ignored requests, reset abort.
module tb_adld_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef ADLD_OVF_EN
    logic        ovf;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    adld_seq_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef ADLD_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef ADLD_OVF_EN
        check(tag, {31'd0, ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable %s", tag);
`endif
    endtask

    // Accept one request at the next rising edge; returns at the following negedge.
    task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check_ovf({tag, "_ovf"}, eo);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec, input logic eo);
        accept(av, bv, cv);
        wait_done(tag, 4);
        check_result(tag, es, ec, eo);
        $display("%s: 0x%04h + 0x%04h + %0d -> sum=0x%04h cout=%0d", tag, av, bv, cv, sum, cout);
        release_result(tag);
    endtask

    initial begin
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check_ovf("rst_ovf", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("pos_ovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("idle_holds_sum", {16'd0, sum}, 32'h0000);
        check("idle_holds_cout", {31'd0, cout}, 32'd1);

        // Backpressure: result frozen while out_ready stays low
        accept(16'hA5A5, 16'h1111, 1'b0);
        wait_done("bp", 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_sum", {16'd0, sum}, 32'hB6B6);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        check_result("bp", 16'hB6B6, 1'b0, 1'b0);
        $display("bp: 0xa5a5 + 0x1111 held 5 cycles -> sum=0x%04h", sum);
        release_result("bp");

        // A request presented during RUN must be dropped, not queued
        accept(16'h0101, 16'h0202, 1'b0);
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_done("ignore", 3);
        check_result("ignore", 16'h0303, 1'b0, 1'b0);
        $display("ignore: 0x0101 + 0x0202 with mid-RUN poke -> sum=0x%04h", sum);
        release_result("ignore");
        @(posedge clk);
        @(negedge clk);
        check("ignore_not_queued", {31'd0, busy}, 32'd0);

        // Reset abort after two RUN edges leaves carry_q set internally
        accept(16'h00FF, 16'h00FF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check_ovf("abort_ovf", 1'b0);
        $display("abort: reset asserted mid-RUN -> sum=0x%04h busy=%0d", sum, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_stays_idle", {31'd0, out_valid}, 32'd0);
        run_op("post_reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
